// File: rtl/decoder_sel_sequencer.sv
// Command FIFO plus hold sequencer that drives the a/b select inputs of a 2-to-4 decoder.
// Each queued code is presented for max(dwell,1) cycles, back to back, in arrival order.
module decoder_sel_sequencer #(
    parameter int DEPTH   = 4,
    parameter int DWELL_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [1:0]                 in_code,
    input  logic [DWELL_W-1:0]         in_dwell,
    input  logic                       flush,
    output logic                       a,
    output logic                       b,
    output logic                       sel_valid,
    output logic                       done,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);
    localparam int ENT_W = DWELL_W + 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    logic [ENT_W-1:0]   fifo_mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [LVL_W-1:0]   level_r;
    state_t             state_r;
    state_t             state_n_s;
    logic [1:0]         code_r;
    logic [1:0]         code_n_s;
    logic [DWELL_W-1:0] cnt_r;
    logic [DWELL_W-1:0] cnt_n_s;
    logic               sel_valid_r;
    logic               sel_valid_n_s;
    logic               done_r;
    logic               done_n_s;
    logic               pop_s;
    logic               push_s;
    logic               empty_s;
    logic               full_s;
    logic [ENT_W-1:0]   head_s;
    logic [1:0]         head_code_s;
    logic [DWELL_W-1:0] head_dwell_s;

    assign empty_s      = (level_r == LVL_W'(0));
    assign full_s       = (level_r == LVL_W'(DEPTH));
    assign in_ready     = ~full_s & ~flush & rst_n;
    assign push_s       = in_valid & in_ready;
    assign head_s       = fifo_mem_r[rd_ptr_r];
    assign head_code_s  = head_s[ENT_W-1:DWELL_W];
    assign head_dwell_s = (head_s[DWELL_W-1:0] == DWELL_W'(0)) ? DWELL_W'(1) : head_s[DWELL_W-1:0];

    assign a         = code_r[1];
    assign b         = code_r[0];
    assign sel_valid = sel_valid_r;
    assign done      = done_r;
    assign level     = level_r;
    assign busy      = sel_valid_r | ~empty_s;

    // FIFO storage; entries are only meaningful while counted by level_r
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= {in_code, in_dwell};
        end
    end

    // FIFO pointers and occupancy; flush clears everything, including a same-cycle pop
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            level_r  <= LVL_W'(0);
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LVL_W'(1);
                2'b01:   level_r <= level_r - LVL_W'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Next-state logic; done is registered as "the coming cycle is the last hold cycle"
    always_comb begin
        state_n_s     = state_r;
        code_n_s      = code_r;
        cnt_n_s       = cnt_r;
        sel_valid_n_s = sel_valid_r;
        pop_s         = 1'b0;
        case (state_r)
            IDLE: begin
                if (!empty_s) begin
                    pop_s         = 1'b1;
                    state_n_s     = HOLD;
                    code_n_s      = head_code_s;
                    cnt_n_s       = head_dwell_s;
                    sel_valid_n_s = 1'b1;
                end else begin
                    code_n_s      = 2'b00;
                    cnt_n_s       = DWELL_W'(0);
                    sel_valid_n_s = 1'b0;
                end
            end
            HOLD: begin
                if (cnt_r != DWELL_W'(1)) begin
                    cnt_n_s = cnt_r - DWELL_W'(1);
                end else if (!empty_s) begin
                    pop_s         = 1'b1;
                    code_n_s      = head_code_s;
                    cnt_n_s       = head_dwell_s;
                    sel_valid_n_s = 1'b1;
                end else begin
                    state_n_s     = IDLE;
                    code_n_s      = 2'b00;
                    cnt_n_s       = DWELL_W'(0);
                    sel_valid_n_s = 1'b0;
                end
            end
            default: begin
                state_n_s     = IDLE;
                code_n_s      = 2'b00;
                cnt_n_s       = DWELL_W'(0);
                sel_valid_n_s = 1'b0;
            end
        endcase
        if (flush) begin
            pop_s         = 1'b0;
            state_n_s     = IDLE;
            code_n_s      = 2'b00;
            cnt_n_s       = DWELL_W'(0);
            sel_valid_n_s = 1'b0;
        end else begin
            pop_s = pop_s;
        end
        done_n_s = (state_n_s == HOLD) && (cnt_n_s == DWELL_W'(1));
    end

    // Sequencer state and registered decoder-side outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            code_r      <= 2'b00;
            cnt_r       <= DWELL_W'(0);
            sel_valid_r <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_n_s;
            code_r      <= code_n_s;
            cnt_r       <= cnt_n_s;
            sel_valid_r <= sel_valid_n_s;
            done_r      <= done_n_s;
        end
    end
endmodule
